// File: rtl/miss_tracker_pkg.sv
// Shared types and defaults for the miss tracker and its blink timer.
package miss_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      FLASH = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam int MISS_W           = 2;
   localparam int FLASH_CYCLES_DEF = 25_000_000;
   localparam int BLINK_CYCLES_DEF = 6_250_000;

   // Counter width for a 0..n-1 counter, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/miss_tracker_blink_timer.sv
// Free-running blink phase generator: phase toggles each BLINK_CYCLES enabled cycles.
// Clear restarts the count with the phase in its blanked half.
module blink_timer
   import miss_pkg::*;
#(
   parameter int BLINK_CYCLES = BLINK_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic phase
);

   localparam int            BW         = cnt_width(BLINK_CYCLES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic [BW-1:0] cnt_d, cnt_q;
   logic          phase_d, phase_q;

   // Next count and phase; clear takes priority over enable.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (clear) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (enable) begin
         if (cnt_q == BLINK_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + BW'(1);
            phase_d = phase_q;
         end
      end else begin
         cnt_d   = cnt_q;
         phase_d = phase_q;
      end
   end

   // Count and phase registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/miss_tracker.sv
// Miss counter with grace/flash window and game-over detection for the HEX4 display path.
// A miss is one rising edge of miss_in; only edges seen in unpaused PLAY without start count.
module miss_tracker
   import miss_pkg::*;
#(
   parameter int MAX_MISS     = 3,
   parameter int FLASH_CYCLES = FLASH_CYCLES_DEF,
   parameter int BLINK_CYCLES = BLINK_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              miss_in,
   output logic [MISS_W-1:0] miss_count,
   output logic              display_blank,
   output logic              game_over,
   output logic              miss_dropped
);

   localparam int                FW         = cnt_width(FLASH_CYCLES);
   localparam logic [FW-1:0]     FLASH_LAST = FW'(FLASH_CYCLES - 1);
   localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MAX_MISS - 1);

   state_t            state_d, state_q;
   logic [MISS_W-1:0] count_d, count_q;
   logic [FW-1:0]     flash_d, flash_q;
   logic              miss_d, miss_q;
   logic              dropped_d, dropped_q;
   logic              miss_edge, accept;
   logic              blink_clear, blink_en, blink_phase;

   assign miss_edge = miss_in & ~miss_q;
   assign accept    = miss_edge & (state_q == PLAY) & ~pause & ~start;

   // Next-state, count, flash timer and drop strobe.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      flash_d   = flash_q;
      miss_d    = miss_in;
      dropped_d = miss_edge & ~accept;
      if (start) begin
         state_d = PLAY;
         count_d = '0;
         flash_d = '0;
      end else if (pause) begin
         state_d = state_q;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            PLAY: begin
               if (miss_edge) begin
                  count_d = count_q + MISS_W'(1);
                  flash_d = '0;
                  state_d = (count_q == MISS_LAST) ? OVER : FLASH;
               end else begin
                  state_d = PLAY;
               end
            end
            FLASH: begin
               if (flash_q == FLASH_LAST) begin
                  state_d = PLAY;
                  flash_d = '0;
               end else begin
                  flash_d = flash_q + FW'(1);
               end
            end
            OVER: begin
               state_d = OVER;
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
               flash_d = '0;
            end
         endcase
      end
   end

   // Blink restarts on every entry into FLASH/OVER and is held in reset elsewhere.
   assign blink_clear = ~((state_d == FLASH) | (state_d == OVER)) | (state_d != state_q);
   assign blink_en    = ((state_q == FLASH) | (state_q == OVER)) & ~pause;

   blink_timer #(
      .BLINK_CYCLES(BLINK_CYCLES)
   ) u_blink (
      .clk   (clk),
      .reset (reset),
      .clear (blink_clear),
      .enable(blink_en),
      .phase (blink_phase)
   );

   // State, counter and edge registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         flash_q   <= '0;
         miss_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         flash_q   <= flash_d;
         miss_q    <= miss_d;
         dropped_q <= dropped_d;
      end
   end

   assign miss_count    = count_q;
   assign game_over     = (state_q == OVER);
   assign display_blank = blink_phase & ((state_q == FLASH) | (state_q == OVER));
   assign miss_dropped  = dropped_q;

endmodule

// File: tb/tb_miss_tracker.sv
// Scoreboard bench for miss_tracker: a behavioural model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_miss_tracker;

   localparam int MAXM  = 3;
   localparam int FLASH = 20;
   localparam int BLINK = 5;

   localparam int M_IDLE  = 0;
   localparam int M_PLAY  = 1;
   localparam int M_FLASH = 2;
   localparam int M_OVER  = 3;

   logic       clk = 1'b0;
   logic       reset, start, pause, miss_in;
   logic [1:0] miss_count;
   logic       display_blank, game_over, miss_dropped;

   typedef struct {
      int cnt;
      int blank;
      int over;
      int drop;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;

   // Model variables: mode, misses, time elapsed in current window, previous miss_in.
   int   mode = M_IDLE;
   int   misses = 0;
   int   t = 0;
   int   drop = 0;
   bit   prev_miss = 1'b0;
   bit   edge_s;

   miss_tracker #(
      .MAX_MISS    (MAXM),
      .FLASH_CYCLES(FLASH),
      .BLINK_CYCLES(BLINK)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .pause        (pause),
      .miss_in      (miss_in),
      .miss_count   (miss_count),
      .display_blank(display_blank),
      .game_over    (game_over),
      .miss_dropped (miss_dropped)
   );

   always #5 clk = ~clk;

   // Reference model: evaluate the game rules once per clock and queue the expected outputs.
   always @(posedge clk) begin
      exp_t e;
      cycle  = cycle + 1;
      edge_s = miss_in && !prev_miss;
      drop   = 0;
      if (reset) begin
         mode = M_IDLE; misses = 0; t = 0; prev_miss = 1'b0;
      end else begin
         prev_miss = miss_in;
         if (start) begin
            if (edge_s) drop = 1;
            mode = M_PLAY; misses = 0; t = 0;
         end else if (pause) begin
            if (edge_s) drop = 1;
         end else if (mode == M_PLAY) begin
            if (edge_s) begin
               misses = misses + 1;
               t      = 0;
               mode   = (misses == MAXM) ? M_OVER : M_FLASH;
            end
         end else if (mode == M_FLASH) begin
            if (edge_s) drop = 1;
            if (t == FLASH - 1) begin
               mode = M_PLAY; t = 0;
            end else begin
               t = t + 1;
            end
         end else if (mode == M_OVER) begin
            if (edge_s) drop = 1;
            t = t + 1;
         end else begin
            if (edge_s) drop = 1;
         end
      end
      e.cnt   = misses;
      e.over  = (mode == M_OVER) ? 1 : 0;
      e.blank = ((mode == M_FLASH || mode == M_OVER) && ((t / BLINK) % 2 == 0)) ? 1 : 0;
      e.drop  = drop;
      e.cyc   = cycle;
      exp_q.push_back(e);
   end

   task automatic check(input string name, input int cyc, input int got, input int want);
      n_checks = n_checks + 1;
      if (got != want) begin
         n_fail = n_fail + 1;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
      end
   endtask

   // Monitor: compare each queued expectation with the DUT outputs between clock edges.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("miss_count",    e.cyc, int'(miss_count),    e.cnt);
         check("game_over",     e.cyc, int'(game_over),     e.over);
         check("display_blank", e.cyc, int'(display_blank), e.blank);
         check("miss_dropped",  e.cyc, int'(miss_dropped),  e.drop);
      end
   end

   task automatic cyc(input bit r, input bit s, input bit p, input bit m, input int n);
      reset   = r;
      start   = s;
      pause   = p;
      miss_in = m;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      bit p_lvl = 1'b0;
      bit m_lvl = 1'b0;
      cyc(1, 0, 0, 0, 3);
      cyc(0, 0, 0, 0, 2);
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 2);            // miss in IDLE is dropped
      cyc(0, 1, 0, 0, 1); cyc(0, 0, 0, 0, 3);
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 5);            // first miss, flash window
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 20);           // grace-period miss dropped
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 6);            // second miss
      cyc(0, 0, 1, 0, 7); cyc(0, 0, 0, 0, 20);           // pause mid-flash
      cyc(0, 1, 0, 0, 1); cyc(0, 0, 0, 0, 2);
      cyc(0, 0, 0, 1, 30); cyc(0, 0, 0, 0, 25);          // held level counts once
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 25);
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 17);           // final miss, OVER blinking
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 12);
      cyc(0, 0, 1, 0, 4);
      cyc(0, 1, 0, 0, 1);
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 25);
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 25);
      cyc(0, 1, 0, 1, 1); cyc(0, 0, 0, 0, 3);            // start and miss together at count 2
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 25);
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 25);
      cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 8);
      cyc(1, 0, 0, 0, 1); cyc(0, 0, 0, 0, 3);            // reset mid-OVER
      cyc(0, 1, 0, 0, 1);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(49, 0) == 0) p_lvl = ~p_lvl;
         if ($urandom_range(5, 0) == 0)  m_lvl = ~m_lvl;
         cyc(($urandom_range(399, 0) == 0), ($urandom_range(79, 0) == 0), p_lvl, m_lvl, 1);
      end
      cyc(0, 0, 0, 0, 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
